// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//
// Instruction queue between the fetch stage and the scoreboard. Fetch pushes
// one {pc, inst} pair per cycle. The scoreboard consumes up to ISSUE_W head
// entries per cycle in program order. A branch redirect (flush) empties the
// queue. With flush_keep set, a single entry, the MIPS delay slot, is kept.
//
// Parameters
//   DEPTH    : number of entries (power of two, >= 4)
//   ISSUE_W  : number of output slots / max pops per cycle (1..4, <= DEPTH)
//   AFULL_TH : afull asserts when count >= AFULL_TH (1..DEPTH)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   push_valid : fetch presents {push_pc, push_inst} this cycle
//   push_pc    : PC of the pushed instruction
//   push_inst  : instruction word
//   push_ready : !full; a push is taken when push_valid && push_ready
//   pop_cnt    : number of head entries consumed this cycle
//   flush      : branch redirect
//   flush_keep : qualifies flush; keep the delay-slot entry
//   out_valid  : bit i set when slot i holds an entry
//   out_pc     : slot i PC in bits [32i+31:32i], zero when the slot is invalid
//   out_inst   : slot i instruction, same packing as out_pc
//   count      : current occupancy
//   full       : count == DEPTH
//   afull      : count >= AFULL_TH
//
// Every output depends on registered state only, so fetch and the scoreboard
// never see a combinational path through this block.
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH    = 8,
    parameter int ISSUE_W  = 2,
    parameter int AFULL_TH = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_valid,
    input  logic [31:0]                  push_pc,
    input  logic [31:0]                  push_inst,
    output logic                         push_ready,
    input  logic [$clog2(ISSUE_W+1)-1:0] pop_cnt,
    input  logic                         flush,
    input  logic                         flush_keep,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [32*ISSUE_W-1:0]        out_pc,
    output logic [32*ISSUE_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         afull
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Each entry is {pc, inst}.
    logic [63:0]      mem [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic [PTR_W-1:0] head_n, tail_n;
    logic [CNT_W-1:0] count_n;

    logic             full_w;
    logic             push_acc;
    logic             wr_en;
    logic [CNT_W-1:0] pop_req;
    logic [CNT_W-1:0] pop_eff;
    logic [CNT_W-1:0] remain;
    logic [PTR_W-1:0] head_pop;

    // -------------------------------------------------------------------------
    // Handshake and effective pop
    // -------------------------------------------------------------------------
    // Backpressure uses the pre-edge count only: a full queue rejects a push
    // even if the scoreboard frees entries in the same cycle.
    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign push_acc = push_valid && !full_w;

    // pop_cnt can never be wider than count because ISSUE_W <= DEPTH.
    assign pop_req  = CNT_W'(pop_cnt);
    assign pop_eff  = (pop_req < count_q) ? pop_req : count_q;
    assign remain   = count_q - pop_eff;

    // Truncation to PTR_W gives the wrap modulo DEPTH.
    assign head_pop = head_q + PTR_W'(pop_eff);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        head_n  = head_q;
        tail_n  = tail_q;
        count_n = count_q;
        wr_en   = 1'b0;

        if (flush) begin
            if (!flush_keep) begin
                // Plain redirect: drop everything, same-cycle push/pop ignored.
                head_n  = '0;
                tail_n  = '0;
                count_n = '0;
            end else if (remain != '0) begin
                // Delay slot is the first entry left after this cycle's pop.
                head_n  = head_pop;
                tail_n  = head_pop + PTR_W'(1);
                count_n = CNT_W'(1);
            end else if (push_acc) begin
                // Queue drained by the pop: the incoming push is the delay slot.
                wr_en   = 1'b1;
                head_n  = tail_q;
                tail_n  = tail_q + PTR_W'(1);
                count_n = CNT_W'(1);
            end else begin
                // Nothing to keep. After draining, head_pop already equals tail.
                head_n  = tail_q;
                count_n = '0;
            end
        end else begin
            wr_en   = push_acc;
            head_n  = head_pop;
            if (push_acc) begin
                tail_n = tail_q + PTR_W'(1);
            end
            count_n = count_q + CNT_W'(push_acc) - pop_eff;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together
            // from pre-edge values, independent of statement order.
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
        end
    end

    // NOTE: the storage array is deliberately not reset; out_valid and the
    // data gating below hide stale contents, and a reset-free array maps onto
    // plain RAM or cheaper flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail_q] <= {push_pc, push_inst};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registered state only, no input feed-through, no bypass
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
        logic [PTR_W-1:0] idx;
        logic [63:0]      entry;

        assign idx                   = head_q + PTR_W'(i);
        assign entry                 = mem[idx];
        assign out_valid[i]          = (count_q > CNT_W'(i));
        assign out_pc[32*i +: 32]    = out_valid[i] ? entry[63:32] : 32'h0;
        assign out_inst[32*i +: 32]  = out_valid[i] ? entry[31:0]  : 32'h0;
    end

    assign count      = count_q;
    assign full       = full_w;
    assign afull      = (count_q >= CNT_W'(AFULL_TH));
    assign push_ready = !full_w;

    // -------------------------------------------------------------------------
    // Occupancy invariant: count stays within 0..DEPTH and matches the pointer
    // distance. At count == DEPTH the pointers coincide and the low bits of
    // count are zero, so one expression covers every case.
    // -------------------------------------------------------------------------
    assert property (@(posedge clk) disable iff (reset)
        (count_q <= CNT_W'(DEPTH)) &&
        (count_q[PTR_W-1:0] == PTR_W'(tail_q - head_q)))
    else $error("inst_queue occupancy invariant broken");

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//
// Self-checking bench for inst_queue (DEPTH=8, ISSUE_W=2, AFULL_TH=6).
// The reference model is a plain queue of {pc, inst} records updated from the
// queue rules: accept if not full, pop min(pop_cnt, size), flush clears or
// keeps one entry.
// -----------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DEPTH    = 8;
    localparam int ISSUE_W  = 2;
    localparam int AFULL_TH = 6;
    localparam int POP_W    = $clog2(ISSUE_W + 1);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [31:0] INST_KEY = 32'h5A5A_5A5A;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   push_valid;
    logic [31:0]            push_pc;
    logic [31:0]            push_inst;
    logic                   push_ready;
    logic [POP_W-1:0]       pop_cnt;
    logic                   flush;
    logic                   flush_keep;
    logic [ISSUE_W-1:0]     out_valid;
    logic [32*ISSUE_W-1:0]  out_pc;
    logic [32*ISSUE_W-1:0]  out_inst;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   afull;

    inst_queue #(
        .DEPTH    (DEPTH),
        .ISSUE_W  (ISSUE_W),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_pc    (push_pc),
        .push_inst  (push_inst),
        .push_ready (push_ready),
        .pop_cnt    (pop_cnt),
        .flush      (flush),
        .flush_keep (flush_keep),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .count      (count),
        .full       (full),
        .afull      (afull)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoring
    // -------------------------------------------------------------------------
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t mq[$];

    task automatic model_step(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                              input int pop, input logic fl, input logic fk);
        entry_t e;
        bit     acc;
        int     p;
        acc = pv && (mq.size() < DEPTH);
        p   = (pop < mq.size()) ? pop : mq.size();
        if (fl && !fk) begin
            mq.delete();
        end else begin
            repeat (p) void'(mq.pop_front());
            if (fl) begin
                if (mq.size() >= 1) begin
                    e = mq[0];
                    mq.delete();
                    mq.push_back(e);
                end else if (acc) begin
                    e.pc   = pc;
                    e.inst = inst;
                    mq.push_back(e);
                end
            end else if (acc) begin
                e.pc   = pc;
                e.inst = inst;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [ISSUE_W-1:0]    ev;
        logic [32*ISSUE_W-1:0] ep;
        logic [32*ISSUE_W-1:0] ei;
        ev = '0;
        ep = '0;
        ei = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (i < mq.size()) begin
                ev[i]         = 1'b1;
                ep[32*i +: 32] = mq[i].pc;
                ei[32*i +: 32] = mq[i].inst;
            end
        end
        check($sformatf("%s_count", tag), 128'(count), 128'(mq.size()));
        check($sformatf("%s_valid", tag), 128'(out_valid), 128'(ev));
        check($sformatf("%s_pc", tag), 128'(out_pc), 128'(ep));
        check($sformatf("%s_inst", tag), 128'(out_inst), 128'(ei));
        check($sformatf("%s_full", tag), 128'(full), 128'(mq.size() == DEPTH));
        check($sformatf("%s_afull", tag), 128'(afull), 128'(mq.size() >= AFULL_TH));
        check($sformatf("%s_ready", tag), 128'(push_ready), 128'(mq.size() < DEPTH));
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers: called at the falling edge, return at the next one
    // -------------------------------------------------------------------------
    task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                        input int pop, input logic fl, input logic fk);
        push_valid = pv;
        push_pc    = pc;
        push_inst  = inst;
        pop_cnt    = POP_W'(pop);
        flush      = fl;
        flush_keep = fk;
        @(posedge clk);
        model_step(pv, pc, inst, pop, fl, fk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        push_valid = 1'b0;
        push_pc    = '0;
        push_inst  = '0;
        pop_cnt    = '0;
        flush      = 1'b0;
        flush_keep = 1'b0;
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic        pv;
        logic [31:0] pc;
        int          pop;
        logic        fl;
        logic        fk;
        int          exp_cnt;
        logic [1:0]  exp_valid;
        logic [31:0] exp_s0;
        logic [31:0] exp_s1;
        logic        exp_full;
        logic        exp_afull;
    } vec_t;

    function automatic vec_t mk(input logic pv, input logic [31:0] pc, input int pop,
                                input logic fl, input logic fk, input int cnt,
                                input logic [1:0] v, input logic [31:0] s0,
                                input logic [31:0] s1, input logic fu, input logic af);
        vec_t r;
        r.pv = pv; r.pc = pc; r.pop = pop; r.fl = fl; r.fk = fk;
        r.exp_cnt = cnt; r.exp_valid = v; r.exp_s0 = s0; r.exp_s1 = s1;
        r.exp_full = fu; r.exp_afull = af;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] pc;
        logic [31:0] nxt_pop;
        logic [31:0] inst0;
        int          pop;
        logic        pv;
        logic        fl;
        logic        fk;

        //         pv    pc            pop fl  fk  cnt valid  s0            s1            full afull
        vecs.push_back(mk(1, 32'hBFC00000, 0, 0, 0, 1, 2'b01, 32'hBFC00000, 32'h0,        0, 0));
        vecs.push_back(mk(1, 32'hBFC00004, 0, 0, 0, 2, 2'b11, 32'hBFC00000, 32'hBFC00004, 0, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 0, 0, 0, 3, 2'b11, 32'hBFC00000, 32'hBFC00004, 0, 0));
        vecs.push_back(mk(1, 32'hBFC0000C, 0, 0, 0, 4, 2'b11, 32'hBFC00000, 32'hBFC00004, 0, 0));
        vecs.push_back(mk(1, 32'hBFC00010, 0, 0, 0, 5, 2'b11, 32'hBFC00000, 32'hBFC00004, 0, 0));
        vecs.push_back(mk(1, 32'hBFC00014, 0, 0, 0, 6, 2'b11, 32'hBFC00000, 32'hBFC00004, 0, 1));
        vecs.push_back(mk(1, 32'hBFC00018, 0, 0, 0, 7, 2'b11, 32'hBFC00000, 32'hBFC00004, 0, 1));
        vecs.push_back(mk(1, 32'hBFC0001C, 0, 0, 0, 8, 2'b11, 32'hBFC00000, 32'hBFC00004, 1, 1));
        // Full: push rejected although two entries leave this cycle.
        vecs.push_back(mk(1, 32'hBFC00020, 2, 0, 0, 6, 2'b11, 32'hBFC00008, 32'hBFC0000C, 0, 1));
        vecs.push_back(mk(0, 32'h0,        1, 0, 0, 5, 2'b11, 32'hBFC0000C, 32'hBFC00010, 0, 0));
        // Plain flush at count=5 with push and pop: everything dropped.
        vecs.push_back(mk(1, 32'hAAAA0000, 1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(1, 32'h80000000, 0, 0, 0, 1, 2'b01, 32'h80000000, 32'h0,        0, 0));
        vecs.push_back(mk(1, 32'h80000004, 0, 0, 0, 2, 2'b11, 32'h80000000, 32'h80000004, 0, 0));
        vecs.push_back(mk(1, 32'h80000008, 0, 0, 0, 3, 2'b11, 32'h80000000, 32'h80000004, 0, 0));
        vecs.push_back(mk(1, 32'h8000000C, 0, 0, 0, 4, 2'b11, 32'h80000000, 32'h80000004, 0, 0));
        // Keep-flush at count=4 with pop 1: A+4 survives, push dropped.
        vecs.push_back(mk(1, 32'hDEAD0000, 1, 1, 1, 1, 2'b01, 32'h80000004, 32'h0,        0, 0));
        // Keep-flush draining the last entry: the same-cycle push is the delay slot.
        vecs.push_back(mk(1, 32'h80000010, 1, 1, 1, 1, 2'b01, 32'h80000010, 32'h0,        0, 0));
        // Keep-flush draining the last entry, no push: empty.
        vecs.push_back(mk(0, 32'h0,        1, 1, 1, 0, 2'b00, 32'h0,        32'h0,        0, 0));
        // flush_keep alone has no effect.
        vecs.push_back(mk(1, 32'h12340000, 0, 0, 1, 1, 2'b01, 32'h12340000, 32'h0,        0, 0));
        // Keep-flush with no pop: head survives, push dropped.
        vecs.push_back(mk(1, 32'h12340004, 0, 1, 1, 1, 2'b01, 32'h12340000, 32'h0,        0, 0));

        // ---------------- Reset state ----------------
        reset = 1'b1;
        apply_reset();
        check("rst_count", 128'(count), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_full", 128'(full), 128'(0));
        check("rst_afull", 128'(afull), 128'(0));
        check("rst_ready", 128'(push_ready), 128'(1));

        // Reset in the middle of traffic, then restart.
        step(1, 32'h11110000, 32'h1, 0, 0, 0);
        step(1, 32'h11110004, 32'h2, 0, 0, 0);
        apply_reset();
        check("rst2_count", 128'(count), 128'(0));

        // ---------------- Directed table ----------------
        foreach (vecs[i]) begin
            step(vecs[i].pv, vecs[i].pc, vecs[i].pc ^ INST_KEY, vecs[i].pop, vecs[i].fl, vecs[i].fk);
            inst0 = vecs[i].exp_valid[0] ? (vecs[i].exp_s0 ^ INST_KEY) : 32'h0;
            check($sformatf("vec%0d_count", i), 128'(count), 128'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i), 128'(out_pc), 128'({vecs[i].exp_s1, vecs[i].exp_s0}));
            check($sformatf("vec%0d_inst0", i), 128'(out_inst[31:0]), 128'(inst0));
            check($sformatf("vec%0d_full", i), 128'(full), 128'(vecs[i].exp_full));
            check($sformatf("vec%0d_afull", i), 128'(afull), 128'(vecs[i].exp_afull));
            check($sformatf("vec%0d_ready", i), 128'(push_ready), 128'(!vecs[i].exp_full));
        end

        // ---------------- Asynchronous reset with count=1 ----------------
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 128'(count), 128'(0));
        check("arst_valid", 128'(out_valid), 128'(0));
        check("arst_pc", 128'(out_pc), 128'(0));
        check("arst_inst", 128'(out_inst), 128'(0));
        check("arst_ready", 128'(push_ready), 128'(1));
        apply_reset();

        // ---------------- Steady stream with pointer wrap ----------------
        pc      = 32'h00400000;
        nxt_pop = 32'h00400000;
        for (int c = 0; c < 40; c++) begin
            pop = (mq.size() >= 2) ? 2 : 0;
            for (int k = 0; k < pop; k++) begin
                check($sformatf("stream%0d_pop%0d", c, k), 128'(out_pc[32*k +: 32]), 128'(nxt_pop));
                nxt_pop = nxt_pop + 32'd4;
            end
            step(1'b1, pc, ~pc, pop, 1'b0, 1'b0);
            pc = pc + 32'd4;
            check_model($sformatf("stream%0d", c));
        end

        // ---------------- Randomised traffic against the model ----------------
        apply_reset();
        pc = 32'h9FC00000;
        for (int c = 0; c < 300; c++) begin
            pv  = ($urandom_range(0, 9) < 7);
            // First half pops rarely so the queue fills and backpressure shows up.
            if (c < 150) pop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 0;
            else         pop = int'($urandom_range(0, 2));
            fl  = ($urandom_range(0, 19) == 0);
            fk  = $urandom_range(0, 1) == 1;
            step(pv, pc, $urandom, pop, fl, fk);
            pc = pc + 32'd4;
            check_model($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised instruction queue between the fetch stage and the scoreboard. Generalises the single-instruction fetch-to-issue handoff.
- Fetch pushes one {pc, inst} pair per cycle. The scoreboard pops up to ISSUE_W entries per cycle in program order.
- Branch redirect flushes the queue. Optionally one entry, the MIPS delay slot, is kept.
- full/afull provide registered backpressure to fetch.

Parameters:
- DEPTH, 8: number of entries. Power of two, minimum 4.
- ISSUE_W, 2: number of output slots and maximum pops per cycle. Range 1..4, must be ≤ DEPTH.
- AFULL_TH, 6: afull asserts when count ≥ AFULL_TH. Range 1..DEPTH.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- push_valid, input, 1: fetch presents an instruction this cycle.
- push_pc, input, 32: PC of the pushed instruction.
- push_inst, input, 32: instruction word.
- push_ready, output, 1: equals !full. A push is accepted only when push_valid && push_ready.
- pop_cnt, input, $clog2(ISSUE_W+1): number of head entries consumed this cycle.
- flush, input, 1: branch redirect, connected to br_e.
- flush_keep, input, 1: qualifies flush; retain the delay-slot entry.
- out_valid, output, ISSUE_W: bit i = slot i holds an entry.
- out_pc, output, 32*ISSUE_W: slot i PC in bits [32i+31:32i].
- out_inst, output, 32*ISSUE_W: slot i instruction, same packing as out_pc.
- count, output, $clog2(DEPTH)+1: current occupancy.
- full, output, 1: count == DEPTH.
- afull, output, 1: count ≥ AFULL_TH.

Behaviour:
- Storage:
  - Circular array of DEPTH entries, each 64 bits {pc, inst}.
  - head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register.
- Reset (asynchronous, immediate, also mid-operation): head=tail=count=0, full=afull=0, push_ready=1, out_valid=0. Array contents need not be reset.
- Outputs:
  - Slot i shows entry (head+i) mod DEPTH; out_valid[i] = (count > i).
  - out_pc and out_inst of invalid slots are forced to 0.
  - All outputs are combinational from registers only. No input-to-output combinational path, including push_ready.
- Latency: a pushed entry is first visible on the outputs the cycle after acceptance. There is no bypass, even when the queue is empty.
- Pop:
  - Effective pop p = min(pop_cnt, count); requests beyond valid entries are ignored.
  - head advances by p with wrap.
- Push: accepted when push_valid && !full, evaluated on the pre-edge count. It writes at tail, then tail advances by 1.
- Simultaneous push and pop, no flush: count_next = count + push_acc − p.
  - When full, a push is rejected even if pop_cnt>0 that cycle.
- Flush with flush_keep=0:
  - Same-cycle pop and push are ignored.
  - Next cycle: head=tail=0, count=0.
- Flush with flush_keep=1:
  - Apply pop p first. Let r = count − p.
  - If r ≥ 1: keep only entry (head+p) mod DEPTH. head←(head+p) mod DEPTH, tail←head+1, count←1. The same-cycle push is dropped.
  - If r == 0 and the push is accepted: the pushed entry is kept as the delay slot. It is written at tail; head←tail, tail←tail+1, count←1.
  - If r == 0 and no push: count←0, head=tail unchanged.
- Flags: full, afull and push_ready are derived from the registered count and update on the same edge as count.
- Wrap: pointers wrap silently. Occupancy is tracked only by count, never by pointer comparison.
- Assertion for verification: count never exceeds DEPTH, never underflows, and equals (tail−head) mod DEPTH except at count==DEPTH.

Test Plan:
1. Reset during operation, then push 3 entries (pc 0xBFC00000/04/08) with pop_cnt=0 → count=3; next cycle out_valid=2'b11, slot0 pc=0xBFC00000, slot1 pc=0xBFC00004.
2. Fill 8 entries with pop_cnt=0 → full=1, push_ready=0, afull=1 from count=6. A 9th push_valid with pop_cnt=2 is rejected; count=6 next cycle.
3. Steady stream: push each cycle while pop_cnt=2 whenever count≥2. Run 40 cycles → pointers wrap ≥3 times and the popped pc sequence is strictly +4 with no loss or duplicate.
4. count=5, flush=1, flush_keep=0, push_valid=1, pop_cnt=1 → next cycle count=0, out_valid=0, next accepted push appears in slot0.
5. count=4 (pcs A,A+4,A+8,A+12), flush=1, flush_keep=1, pop_cnt=1 → count=1, slot0 pc=A+4 (delay slot), out_valid=2'b01.
6. count=1, pop_cnt=1, push pc=0x80000010 accepted, flush=1, flush_keep=1 → count=1, slot0 pc=0x80000010. Assert reset while count=1 → outputs zero immediately, before the next edge.
